// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the EX/MEM pipeline stage register.
// Holds the control-field width, the packed EX/MEM control layout and the
// all-zeros bubble value that is driven downstream whenever no entry is valid.
package pipe_pkg;

  localparam int CTRL_W_DEF = 12;
  localparam int DATA_W_DEF = 160;

  // EX/MEM control field, MSB first. Any write enable in here must be zero
  // in a bubble, which the all-zeros constant below guarantees.
  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic [1:0] bhw;
    logic       regWrite;
    logic       regDst;
    logic [1:0] memToReg;
    logic       branch;
    logic       jump;
    logic       aluSrc;
    logic       spare;
  } ex_mem_ctrl_t;

  localparam ex_mem_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_entry.sv
// pipe_stage_entry: one valid + ctrl + data holding register.
// rst clears everything including payload; clear only drops valid so the
// payload keeps its last value. The ctrl output is masked to the bubble
// value whenever the entry is not valid.
module pipe_stage_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] inCtrl,
  input  logic [DATA_W-1:0] inData,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              validQ;
  logic [CTRL_W-1:0] ctrlQ;
  logic [DATA_W-1:0] dataQ;

  // Entry register: reset wipes payload, clear only invalidates, load captures.
  always_ff @(posedge clk) begin
    if (rst) begin
      validQ <= 1'b0;
      ctrlQ  <= '0;
      dataQ  <= '0;
    end else if (clear) begin
      validQ <= 1'b0;
    end else if (load) begin
      validQ <= 1'b1;
      ctrlQ  <= inCtrl;
      dataQ  <= inData;
    end
  end

  assign valid = validQ;
  assign ctrl  = validQ ? ctrlQ : CTRL_W'(CTRL_BUBBLE);
  assign data  = dataQ;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: EX/MEM pipeline stage register with valid/ready flow control.
// Handshake: an entry moves across a port on a rising edge where both valid
// and ready are high; valid never depends on ready of the same port.
// Build option PIPE_STAGE_REG_SKID_EN: two entries (main + skid) with a
// registered in_ready; otherwise a single entry with pass-through in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              mainValid;
  logic              mainLoad;
  logic              mainClear;
  logic [CTRL_W-1:0] mainInCtrl;
  logic [DATA_W-1:0] mainInData;
  logic              accept;
  logic              emit;

  assign accept = in_valid && in_ready;
  assign emit   = mainValid && out_ready;

`ifdef PIPE_STAGE_REG_SKID_EN

  logic              skidValid;
  logic              skidLoad;
  logic              skidClear;
  logic [CTRL_W-1:0] skidCtrl;
  logic [DATA_W-1:0] skidData;

  // Skid register is a flop output, so in_ready has no path from out_ready.
  assign in_ready = !skidValid;

  // Steer loads: refill main from skid first, else from the input; park the
  // input in skid only when main is held and not draining.
  always_comb begin
    mainLoad   = 1'b0;
    mainClear  = 1'b0;
    skidLoad   = 1'b0;
    skidClear  = 1'b0;
    mainInCtrl = in_ctrl;
    mainInData = in_data;
    if (flush) begin
      mainClear = 1'b1;
      skidClear = 1'b1;
    end else if (skidValid) begin
      if (emit) begin
        mainLoad   = 1'b1;
        mainInCtrl = skidCtrl;
        mainInData = skidData;
        skidClear  = 1'b1;
      end
    end else if (!mainValid) begin
      mainLoad = accept;
    end else if (emit) begin
      mainLoad  = accept;
      mainClear = !accept;
    end else begin
      skidLoad = accept;
    end
  end

  pipe_stage_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) uSkid (
    .clk    (clk),
    .rst    (rst),
    .load   (skidLoad),
    .clear  (skidClear),
    .inCtrl (in_ctrl),
    .inData (in_data),
    .valid  (skidValid),
    .ctrl   (skidCtrl),
    .data   (skidData)
  );

  assign occupancy = {1'b0, mainValid} + {1'b0, skidValid};

`else

  // Single entry: free a slot in the same cycle the held entry leaves.
  assign in_ready = !mainValid || out_ready;

  // Load on accept (which also covers replace-on-emit), else drop on emit.
  always_comb begin
    mainInCtrl = in_ctrl;
    mainInData = in_data;
    mainLoad   = !flush && accept;
    mainClear  = flush || (emit && !accept);
  end

  assign occupancy = {1'b0, mainValid};

`endif

  pipe_stage_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) uMain (
    .clk    (clk),
    .rst    (rst),
    .load   (mainLoad),
    .clear  (mainClear),
    .inCtrl (mainInCtrl),
    .inData (mainInData),
    .valid  (mainValid),
    .ctrl   (out_ctrl),
    .data   (out_data)
  );

  assign out_valid = mainValid;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: self-checking bench for pipe_stage_reg.
// Reference model: a bounded FIFO of held entries (capacity 2 with
// PIPE_STAGE_REG_SKID_EN, else 1), plus the last payload shown downstream.
module tb_pipe_stage_reg;

  localparam int DW = 160;
  localparam int CW = 12;
  localparam int W  = CW + DW;
`ifdef PIPE_STAGE_REG_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  // scoreboard state
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] hold_data;
  bit            model_known = 1'b0;
  bit            stream_mode = 1'b0;
  int            next_idx = 0;
  int            emitted = 0;
  int            checks = 0;
  int            errors = 0;

  task automatic check_val(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready(input bit ordy);
    if (SKID) return exp_q.size() < 2;
    return (exp_q.size() == 0) || ordy;
  endfunction

  // driver task: one clock cycle of stimulus, output check and model update
  task automatic step(input bit iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                      input bit ordy, input bit fl, input bit rs, output bit accepted);
    bit emit;
    logic [W-1:0] head;
    @(negedge clk);
    in_valid = iv; in_ctrl = ic; in_data = id;
    out_ready = ordy; flush = fl; rst = rs;
    #1;
    accepted = 1'b0;
    if (model_known) begin
      check_val("in_ready", 192'(in_ready), 192'(model_ready(ordy)));
      check_val("out_valid", 192'(out_valid), 192'(exp_q.size() != 0));
      check_val("occupancy", 192'(occupancy), 192'(exp_q.size()));
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        check_val("out_ctrl", 192'(out_ctrl), 192'(head[W-1:DW]));
        check_val("out_data", 192'(out_data), 192'(head[DW-1:0]));
      end else begin
        check_val("bubble_ctrl", 192'(out_ctrl), 192'(0));
        check_val("held_data", 192'(out_data), 192'(hold_data));
      end
    end
    if (rs) begin
      exp_q.delete();
      hold_data = '0;
      model_known = 1'b1;
    end else if (model_known) begin
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        hold_data = head[DW-1:0];
      end
      if (fl) begin
        exp_q.delete();
      end else begin
        accepted = iv && model_ready(ordy);
        emit = (exp_q.size() != 0) && ordy;
        if (emit) begin
          head = exp_q.pop_front();
          if (stream_mode) begin
            check_val("order", 192'(head[31:0]), 192'(next_idx));
            next_idx++;
            emitted++;
          end
        end
        if (accepted) exp_q.push_back({ic, id});
      end
    end
    @(posedge clk);
  endtask

  function automatic logic [DW-1:0] rand_data(input int idx);
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
    d[31:0] = 32'(idx);
    return d;
  endfunction

  initial begin
    bit acc;
    int sent;
    int cyc;
    in_valid = 0; in_ctrl = '0; in_data = '0; out_ready = 0; flush = 0; rst = 1;

    // reset, then first entry: one-cycle latency
    step(0, '0, '0, 0, 0, 1, acc);
    step(0, '0, '0, 0, 0, 1, acc);
    step(1, 12'h0A5, DW'(16'h1234), 1, 0, 0, acc);
    #2;
    check_val("first_valid", 192'(out_valid), 192'(1));
    check_val("first_ctrl", 192'(out_ctrl), 192'(12'h0A5));
    check_val("first_data", 192'(out_data), 192'(16'h1234));
    check_val("first_occ", 192'(occupancy), 192'(1));
    step(0, '0, '0, 1, 0, 0, acc);

    // back-pressure: A then B with out_ready low
    step(1, 12'h001, DW'(8'h11), 0, 0, 0, acc);
    step(1, 12'h002, DW'(8'h22), 0, 0, 0, acc);
    #2;
    if (SKID) begin
      check_val("bp_occ", 192'(occupancy), 192'(2));
      check_val("bp_ready", 192'(in_ready), 192'(0));
    end else begin
      check_val("bp_occ", 192'(occupancy), 192'(1));
      check_val("bp_data", 192'(out_data), 192'(8'h11));
    end
    step(0, '0, '0, 1, 0, 0, acc);
    #2;
    if (SKID) begin
      check_val("drain_ready", 192'(in_ready), 192'(1));
      check_val("drain_data", 192'(out_data), 192'(8'h22));
      check_val("drain_valid", 192'(out_valid), 192'(1));
    end else begin
      check_val("drain_valid", 192'(out_valid), 192'(0));
    end
    step(0, '0, '0, 1, 0, 0, acc);

    // fill, then flush while offering C
    step(1, 12'h003, DW'(8'h44), 0, 0, 0, acc);
    step(1, 12'h004, DW'(8'h55), 0, 0, 0, acc);
    step(1, 12'hFFF, DW'(8'h33), 0, 1, 0, acc);
    #2;
    check_val("flush_valid", 192'(out_valid), 192'(0));
    check_val("flush_ctrl", 192'(out_ctrl), 192'(0));
    check_val("flush_occ", 192'(occupancy), 192'(0));
    for (int i = 0; i < 3; i++) step(0, '0, '0, 1, 0, 0, acc);

    // mid-operation reset while full
    step(1, 12'h005, DW'(8'h66), 0, 0, 0, acc);
    step(1, 12'h006, DW'(8'h77), 0, 0, 0, acc);
    step(1, 12'h007, DW'(8'h88), 0, 0, 1, acc);
    #2;
    check_val("rst_data", 192'(out_data), 192'(0));
    check_val("rst_valid", 192'(out_valid), 192'(0));
    check_val("rst_ready", 192'(in_ready), 192'(1));

    // replace on simultaneous accept and emit, no bubble
    step(1, 12'h008, DW'(8'h99), 0, 0, 0, acc);
    step(1, 12'h009, DW'(8'hAA), 1, 0, 0, acc);
    check_val("replace_acc", 192'(acc), 192'(1));
    #2;
    check_val("replace_valid", 192'(out_valid), 192'(1));
    check_val("replace_data", 192'(out_data), 192'(8'hAA));
    check_val("replace_occ", 192'(occupancy), 192'(1));
    step(0, '0, '0, 1, 0, 0, acc);

    // random stream of 100 entries with random out_ready
    stream_mode = 1'b1;
    sent = 0;
    cyc = 0;
    while ((sent < 100 || exp_q.size() != 0) && cyc < 3000) begin
      step((sent < 100) && ($urandom_range(0, 3) != 0), CW'($urandom), rand_data(sent),
           bit'($urandom_range(0, 1)), 0, 0, acc);
      if (acc) sent++;
      cyc++;
    end
    check_val("stream_done", 192'(cyc < 3000), 192'(1));
    check_val("stream_count", 192'(emitted), 192'(100));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 160, payload width (ReadData1/2, ALUResult, NextInstruct, Instruction).
REQ-002 SHALL have parameter CTRL_W, default 12, control-field width (MemRead, MemWrite, BHW, RegWrite, RegDst, MemToReg, etc.).
REQ-003 SHALL have port clk  in  1  sole clock; all state on posedge clk.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_valid  in  1  upstream entry valid.
REQ-006 SHALL have port in_ready  out  1  stage can accept an entry this cycle.
REQ-007 SHALL have port in_ctrl  in  CTRL_W  upstream control field.
REQ-008 SHALL have port in_data  in  DATA_W  upstream payload.
REQ-009 SHALL have port flush  in  1  discard all held and incoming entries.
REQ-010 SHALL have port out_valid  out  1  downstream entry valid.
REQ-011 SHALL have port out_ready  in  1  downstream accepts this cycle.
REQ-012 SHALL have port out_ctrl  out  CTRL_W  downstream control field.
REQ-013 SHALL have port out_data  out  DATA_W  downstream payload.
REQ-014 SHALL have port occupancy  out  2  number of held entries, 0..2.

Function
REQ-015 SHALL accept an entry when in_valid && in_ready, and emit when out_valid && out_ready.
REQ-016 SHALL deliver entries in order; empty-stage latency in->out of exactly 1 cycle; sustained throughput of 1 entry/cycle when out_ready=1.
REQ-017 SHALL drive out_ctrl to all-zeros (bubble) whenever out_valid=0, so that no write enable can leak downstream.
REQ-018 SHALL hold out_data at its last value while out_valid=0 (payload is don't-care, not cleared).
REQ-019 Skid mode: SHALL hold a main entry and a skid entry; in_ready = !skid_valid, driven from a register with no combinational path from out_ready.
REQ-020 Skid mode, main full and out_ready=0 on accept: SHALL place the new entry in skid; next cycle in_ready=0.
REQ-021 Skid mode, simultaneous accept and emit with skid empty: SHALL replace main with the incoming entry; occupancy unchanged.
REQ-022 Skid mode, emit with skid full: SHALL move skid to main in the same edge; in_ready=1 next cycle.
REQ-023 SHALL ignore in_valid while in_ready=0; held entries SHALL NOT change.
REQ-024 flush SHALL take priority over all transfers: both entries invalidated on that edge, any entry offered that cycle discarded, out_valid=0 and occupancy=0 next cycle.
REQ-025 occupancy SHALL equal the count of valid entries after each edge.

Reset
REQ-026 While rst=1 at posedge clk: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, skid cleared; in_valid ignored.
REQ-027 in_ready SHALL read 1 in the first cycle after rst deasserts.
REQ-028 rst asserted mid-operation SHALL discard held entries exactly as flush does, additionally clearing payload.

Configuration
REQ-029 Macro PIPE_STAGE_REG_SKID_EN defined: SHALL build the 2-entry skid behaviour of REQ-019..022.
REQ-030 Macro undefined: SHALL build a single entry; in_ready = !out_valid || out_ready (combinational); occupancy max 1; all other requirements unchanged.

Structure
REQ-031 SHALL place the control-field width constants, the EX/MEM control-field packed typedef and the all-zeros bubble constant in shared package pipe_pkg.
REQ-032 SHALL use one sub-module, pipe_stage_entry (valid + ctrl + data register with load, clear and bubble-masking), instantiated once or twice.

Verification
REQ-033 Reset then in_valid=1, in_ctrl=0x0A5, in_data=0x1234, out_ready=1 -> next cycle out_valid=1, out_ctrl=0x0A5, out_data=0x1234, occupancy=1.
REQ-034 Skid build: out_ready=0, two entries A=0x11, B=0x22 offered on consecutive cycles -> occupancy 2, in_ready=0; then out_ready=1 -> A emitted, then B, with in_ready=1 one cycle after A is emitted.
REQ-035 Occupancy=2, flush=1 with in_valid=1 carrying C=0x33 -> next cycle out_valid=0, out_ctrl=0, occupancy=0; C never appears.
REQ-036 Stream of 100 entries with out_ready toggled by a random pattern -> all 100 emitted in order, no duplicates, out_ctrl=0 in every cycle with out_valid=0.
REQ-037 rst=1 for one cycle with occupancy=2 -> out_data=0, out_valid=0, in_ready=1 the following cycle.
REQ-038 No-skid build: out_valid=1, out_ready=1, in_valid=1 -> in_ready=1 in the same cycle; the new entry replaces the old one with no bubble.
